// File: rtl/counter_sweep_ctrl.sv
// Drives a universal binary counter through a programmed number of lo->hi->lo sweeps.
// The counter pins are combinational, so the counter turns around in the same cycle q reaches a bound.
module counter_sweep_ctrl #(
  parameter int N        = 8,
  parameter int SWEEPS_W = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic [N-1:0]        lo_val,
  input  logic [N-1:0]        hi_val,
  input  logic [SWEEPS_W-1:0] n_sweeps,
  input  logic [N-1:0]        q,
  input  logic                max_tick,
  input  logic                min_tick,
  output logic                load,
  output logic                up,
  output logic                en,
  output logic                sync_clr,
  output logic [N-1:0]        d,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [SWEEPS_W-1:0] sweep_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    UP    = 3'd3,
    DOWN  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [SWEEPS_W-1:0] SWEEP_ONE = SWEEPS_W'(1);

  state_t              state_q, state_d;
  logic [N-1:0]        lo_q, lo_d;
  logic [N-1:0]        hi_q, hi_d;
  logic [SWEEPS_W-1:0] n_q, n_d;
  logic [SWEEPS_W-1:0] sweep_cnt_q, sweep_cnt_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [SWEEPS_W-1:0] sweep_inc;
  logic                running;

  assign sweep_inc = sweep_cnt_q + SWEEP_ONE;
  assign running   = (state_q == CLEAR) || (state_q == LOAD) ||
                     (state_q == UP)    || (state_q == DOWN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      n_q         <= '0;
      sweep_cnt_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      n_q         <= n_d;
      sweep_cnt_q <= sweep_cnt_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    n_d         = n_q;
    sweep_cnt_d = sweep_cnt_q;
    err_d       = 1'b0;
    load        = 1'b0;
    up          = 1'b1;
    en          = 1'b0;
    sync_clr    = 1'b0;
    d           = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if ((lo_val < hi_val) && (n_sweeps != '0)) begin
            lo_d        = lo_val;
            hi_d        = hi_val;
            n_d         = n_sweeps;
            sweep_cnt_d = '0;
            state_d     = CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        sync_clr = 1'b1;
        en       = 1'b1;
        state_d  = LOAD;
      end
      LOAD: begin
        load    = 1'b1;
        d       = lo_q;
        state_d = UP;
      end
      UP: begin
        en = 1'b1;
        if ((q == hi_q) || max_tick) begin
          up      = 1'b0;
          state_d = DOWN;
        end
      end
      DOWN: begin
        en = 1'b1;
        up = 1'b0;
        if ((q == lo_q) || min_tick) begin
          sweep_cnt_d = sweep_inc;
          // Last sweep: hold the counter at lo rather than bouncing back up.
          if (sweep_inc == n_q) begin
            en      = 1'b0;
            state_d = DONE;
          end else begin
            up      = 1'b1;
            state_d = UP;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort freezes the counter where it is and keeps the partial sweep count.
    if (stop && running) begin
      load        = 1'b0;
      en          = 1'b0;
      sync_clr    = 1'b0;
      up          = 1'b1;
      d           = '0;
      sweep_cnt_d = sweep_cnt_q;
      state_d     = IDLE;
    end

    busy_d = (state_d != IDLE);
  end

  assign busy      = busy_q;
  assign err       = err_q;
  assign sweep_cnt = sweep_cnt_q;
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl with a behavioural univ_bin_counter attached.
// Expected q values per run are queued at start and popped as the DUT sweeps.
module tb_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cnt_rst_n;
  logic       start, stop;
  logic [7:0] lo_val, hi_val;
  logic [3:0] n_sweeps;
  logic [7:0] cnt;
  logic       max_tick, min_tick;
  logic       load, up, en, sync_clr;
  logic [7:0] d;
  logic       busy, done, err;
  logic [3:0] sweep_cnt;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  counter_sweep_ctrl #(.N(8), .SWEEPS_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .lo_val(lo_val), .hi_val(hi_val), .n_sweeps(n_sweeps),
    .q(cnt), .max_tick(max_tick), .min_tick(min_tick),
    .load(load), .up(up), .en(en), .sync_clr(sync_clr), .d(d),
    .busy(busy), .done(done), .err(err), .sweep_cnt(sweep_cnt)
  );

  // univ_bin_counter model, reset independently of the controller
  always_ff @(posedge clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n)    cnt <= 8'd0;
    else if (sync_clr) cnt <= 8'd0;
    else if (load)     cnt <= d;
    else if (en)       cnt <= up ? cnt + 8'd1 : cnt - 8'd1;
  end
  assign max_tick = (cnt == 8'hFF);
  assign min_tick = (cnt == 8'h00);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Full run; disturb pulses start and scrambles inputs mid-run.
  task automatic run_sweep(input int lo, input int hi, input int n, input bit disturb);
    int exp_q[$];
    int exp_len, cyc;
    bit got_done;
    for (int s = 0; s < n; s++) begin
      if (s == 0) exp_q.push_back(lo);
      for (int v = lo + 1; v <= hi; v++) exp_q.push_back(v);
      for (int v = hi - 1; v >= lo; v--) exp_q.push_back(v);
    end
    exp_len  = exp_q.size();
    lo_val   = 8'(lo);
    hi_val   = 8'(hi);
    n_sweeps = 4'(n);
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    cyc      = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        got_done = 1'b1;
      end else begin
        chk("busy_run", busy, 1);
        if (cyc >= 3 && exp_q.size() > 0) chk("q_seq", cnt, exp_q.pop_front());
      end
      if (disturb) begin
        if (cyc == 5) begin
          start = 1'b1; lo_val = 8'd1; hi_val = 8'd9; n_sweeps = 4'd7;
        end else if (cyc == 6) begin
          start = 1'b0;
        end
      end
    end
    chk("done_seen", got_done, 1);
    chk("done_cycle", cyc, 3 + exp_len);
    chk("queue_empty", exp_q.size(), 0);
    chk("sweep_cnt_done", sweep_cnt, n);
    chk("q_at_done", cnt, lo);
    chk("busy_at_done", busy, 1);
    @(negedge clk);
    chk("done_pulse_end", done, 0);
    chk("busy_after", busy, 0);
    chk("q_held", cnt, lo);
    chk("err_run", err, 0);
    $display("run lo=%0d hi=%0d n=%0d disturb=%0d: done at cycle %0d, sweep_cnt=%0d",
             lo, hi, n, disturb, cyc, sweep_cnt);
  endtask

  task automatic run_reject(input int lo, input int hi, input int n);
    @(negedge clk);
    lo_val = 8'(lo); hi_val = 8'(hi); n_sweeps = 4'(n);
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    @(negedge clk);
    chk("err_pulse", err, 1);
    chk("busy_rej", busy, 0);
    chk("en_rej", en, 0);
    chk("load_rej", load, 0);
    chk("clr_rej", sync_clr, 0);
    @(negedge clk);
    chk("err_clear", err, 0);
    chk("busy_rej2", busy, 0);
    $display("reject lo=%0d hi=%0d n=%0d: err=1 for one cycle", lo, hi, n);
  endtask

  initial begin
    int budget;
    reset_n = 1'b0; cnt_rst_n = 1'b0;
    start = 1'b0; stop = 1'b0;
    lo_val = 8'd0; hi_val = 8'd0; n_sweeps = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_sweep", sweep_cnt, 0);
    chk("rst_en", en, 0);
    chk("rst_load", load, 0);
    chk("rst_up", up, 1);
    chk("rst_d", d, 0);
    reset_n = 1'b1; cnt_rst_n = 1'b1;
    @(negedge clk);

    run_sweep(3, 6, 2, 1'b0);
    run_sweep(0, 255, 1, 1'b0);
    run_reject(5, 5, 2);
    run_reject(9, 4, 2);
    run_reject(2, 8, 0);

    // stop in the second sweep at q=7
    @(negedge clk);
    lo_val = 8'd2; hi_val = 8'd10; n_sweeps = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    budget = 0;
    while (!(cnt == 8'd7 && sweep_cnt == 4'd1) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    chk("stop_reached", (cnt == 8'd7 && sweep_cnt == 4'd1), 1);
    stop = 1'b1;
    #1;
    chk("stop_en", en, 0);
    chk("stop_load", load, 0);
    chk("stop_clr", sync_clr, 0);
    @(posedge clk); #1;
    stop = 1'b0;
    @(negedge clk);
    chk("stop_busy", busy, 0);
    chk("stop_q", cnt, 7);
    chk("stop_sweep", sweep_cnt, 1);
    chk("stop_done", done, 0);
    repeat (3) @(negedge clk);
    chk("stop_q_hold", cnt, 7);
    chk("stop_done_late", done, 0);
    $display("stop run lo=2 hi=10 n=3: halted at q=%0d sweep_cnt=%0d", cnt, sweep_cnt);

    // reset while sweeping down
    @(negedge clk);
    lo_val = 8'd3; hi_val = 8'd6; n_sweeps = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_down", {en, up}, 2'b10);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_sweep", sweep_cnt, 0);
    chk("mid_rst_en", en, 0);
    chk("mid_rst_load", load, 0);
    chk("mid_rst_clr", sync_clr, 0);
    chk("mid_rst_up", up, 1);
    chk("mid_rst_d", d, 0);
    $display("reset mid-DOWN: outputs back to reset values, q=%0d", cnt);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_sweep(3, 6, 2, 1'b0);

    // start pulse and input changes mid-run must not alter the sweep
    @(negedge clk);
    run_sweep(3, 6, 2, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
